act_tile_loader: RTL and testbench
==================================

Name: act_tile_loader

Overview:
- Upstream feeder for the double-buffered activation SRAM.
- Accepts a valid/ready stream of IN_W-bit activation beats from DMA and packs them into TM*8-bit rows.
- Writes one row per address into the free ping/pong bank.
- Tracks bank ownership with full flags, which the systolic array controller clears via release pulses once a bank is consumed.

Parameters:
- TM, 16, activation row width in INT8 elements.
- ADDR_WIDTH, 7, row address width; bank depth is 2^ADDR_WIDTH.
- IN_W, 32, input beat width in bits. TM*8 must be an integer multiple of IN_W, otherwise $fatal at elaboration.
- Derived: BEATS = TM*8/IN_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begin loading one tile
- cfg_rows  in  ADDR_WIDTH+1  tile length in rows; sampled on accepted start
- busy  out  1  high from accepted start until return to IDLE
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat ready
- s_data  in  IN_W  stream beat data
- s_last  in  1  final beat of tile
- we  out  1  SRAM write enable
- waddr  out  ADDR_WIDTH  SRAM row address
- wdata  out  TM*8  packed row
- bank_sel_wr  out  1  target bank
- bank_release  in  1  pulse; consumer frees a bank
- release_bank  in  1  bank id freed by bank_release
- bank_full  out  2  per-bank "holds unconsumed tile" flags
- tile_done  out  1  1-cycle pulse at tile completion
- tile_rows  out  ADDR_WIDTH+1  rows written in last completed tile
- err_len  out  1  sticky length mismatch; cleared by accepted start

Behaviour:
- Reset values: all outputs 0; wr_bank=0; bank_full=2'b00; row/beat counters 0; state IDLE.
- All outputs are registered. Reset mid-tile aborts immediately; no further writes occur and partial SRAM contents are undefined.
- cfg_rows handling: 0 or >2^ADDR_WIDTH clamps to 2^ADDR_WIDTH.
- FSM states: IDLE, WAIT_BANK, FILL, DONE.
- IDLE:
  - start is accepted only in IDLE; start in any other state is ignored.
  - On start, go to FILL if bank_full[wr_bank]==0, else WAIT_BANK.
- WAIT_BANK: stay until bank_full[wr_bank]==0, then go to FILL.
- FILL:
  - s_ready=1. A beat is accepted when s_valid&s_ready.
  - Beat k of a row (k=0..BEATS-1) lands at row[k*IN_W +: IN_W].
  - A row completes on the beat with k==BEATS-1, or on any beat with s_last. On s_last mid-row, the remaining lanes are zero-padded.
  - The cycle after row completion: we=1 for exactly 1 cycle, waddr=row index, wdata=packed row, bank_sel_wr=wr_bank.
  - Sustained throughput is 1 beat/cycle; consecutive rows are written back to back.
- Tile end:
  - The tile ends on the completing beat of row cfg_rows-1, or on any s_last beat, whichever comes first. Go to DONE; s_ready=0 from the next cycle.
  - err_len=1 if s_last arrives before row cfg_rows-1 completes, or if the tile ends by count and that beat lacks s_last.
- DONE (1 cycle):
  - The final row's we fires in this cycle.
  - tile_done=1; tile_rows=rows written.
  - At the end of DONE: bank_full[wr_bank]<=1, wr_bank toggles, go to IDLE.
  - First visible: bank_full set the cycle after the last write.
- Bank release:
  - bank_release clears bank_full[release_bank].
  - Release of a non-full bank is ignored.
  - A release and a set to the same bank in the same cycle: the set wins.
  - Release of the other bank is processed independently.
- Counters:
  - Beat counter wraps 0..BEATS-1.
  - Row counter is ADDR_WIDTH+1 bits and never exceeds 2^ADDR_WIDTH.
  - waddr is the low ADDR_WIDTH bits of the row counter.
- busy=1 in WAIT_BANK, FILL and DONE.

Test Plan:
- Reset, then start cfg_rows=2 with 8 beats (IN_W=32, TM=16, BEATS=4), data=beat index, last on beat 7 -> we at addr 0 then 1, bank 0. Row0 lanes = {3,2,1,0}. tile_done with tile_rows=2. bank_full=01. err_len=0.
- Second tile immediately after -> written to bank 1, bank_full=11. Third start -> WAIT_BANK with s_ready=0; release_bank=0 pulse -> fill resumes into bank 0.
- s_last on beat 5 with cfg_rows=4 -> row1 = {0,0,d5,d4}, tile_rows=2, err_len=1. err_len clears on next start.
- cfg_rows=0, 512 beats with last on beat 511 -> 128 writes, waddr 0..127, tile_rows=128, no err.
- Random s_valid gaps; release coincident with DONE on the same bank -> bank_full stays set. Start pulse while busy -> ignored.
- Assert rst_n low mid-FILL -> all outputs 0 next edge; a new start after reset writes bank 0 from addr 0.

Source files
------------

// File: rtl/act_tile_loader_if.sv
// Activation stream (DMA -> loader) and SRAM row-write port bundle for act_tile_loader.
interface act_tile_loader_if #(
  parameter int TM         = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int IN_W       = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [IN_W-1:0]       s_data;
  logic                  s_last;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [TM*8-1:0]       wdata;
  logic                  bank_sel_wr;

  // slave: the loader itself; master: the DMA source plus SRAM sink around it
  modport slave  (input  s_valid, s_data, s_last,
                  output s_ready, we, waddr, wdata, bank_sel_wr);
  modport master (output s_valid, s_data, s_last,
                  input  s_ready, we, waddr, wdata, bank_sel_wr);
endinterface

// File: rtl/act_tile_loader.sv
// Packs IN_W-bit activation beats into TM*8-bit rows and writes whole tiles into
// the free bank of a ping/pong activation SRAM, tracking bank ownership.
module act_tile_loader #(
  parameter int TM         = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int IN_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_rows,
  output logic                  busy,
  act_tile_loader_if.slave      bus,
  input  logic                  bank_release,
  input  logic                  release_bank,
  output logic [1:0]            bank_full,
  output logic                  tile_done,
  output logic [ADDR_WIDTH:0]   tile_rows,
  output logic                  err_len
);
  localparam int ROW_W = TM * 8;
  localparam int BEATS = ROW_W / IN_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH:0] MAX_ROWS = {1'b1, {ADDR_WIDTH{1'b0}}};

  if ((ROW_W % IN_W) != 0) begin : g_bad_width
    $fatal(1, "act_tile_loader: TM*8 must be an integer multiple of IN_W");
  end

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BANK = 2'd1;
  localparam logic [1:0] ST_FILL      = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  logic [1:0]          state;
  logic                wr_bank;
  logic [ADDR_WIDTH:0] row_cnt;
  logic [ADDR_WIDTH:0] rows_target;
  logic [ADDR_WIDTH:0] cfg_clamped;
  logic [BW-1:0]       beat_cnt;
  logic [ROW_W-1:0]    row_buf;
  logic [ROW_W-1:0]    row_next;
  logic [1:0]          full_next;
  logic                beat_ok;
  logic                row_end;
  logic                last_row;
  logic                tile_end;

  // row_buf is cleared after every row, so lanes above the current beat are already zero-padded
  always_comb begin
    beat_ok     = (state == ST_FILL) && bus.s_valid && bus.s_ready;
    row_end     = beat_ok && ((beat_cnt == BW'(BEATS - 1)) || bus.s_last);
    last_row    = (row_cnt == rows_target - 1'b1);
    tile_end    = row_end && (last_row || bus.s_last);
    row_next    = row_buf;
    row_next[int'(beat_cnt) * IN_W +: IN_W] = bus.s_data;
    cfg_clamped = ((cfg_rows == '0) || (cfg_rows > MAX_ROWS)) ? MAX_ROWS : cfg_rows;
  end

  // Set is applied after release so a coincident release of the bank being filled loses
  always_comb begin
    full_next = bank_full;
    if (bank_release)
      full_next[release_bank] = 1'b0;
    if (state == ST_DONE)
      full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      wr_bank         <= 1'b0;
      row_cnt         <= '0;
      rows_target     <= '0;
      beat_cnt        <= '0;
      row_buf         <= '0;
      busy            <= 1'b0;
      bus.s_ready     <= 1'b0;
      bus.we          <= 1'b0;
      bus.waddr       <= '0;
      bus.wdata       <= '0;
      bus.bank_sel_wr <= 1'b0;
      bank_full       <= 2'b00;
      tile_done       <= 1'b0;
      tile_rows       <= '0;
      err_len         <= 1'b0;
    end else begin
      bank_full <= full_next;
      bus.we    <= 1'b0;
      tile_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rows_target <= cfg_clamped;
            row_cnt     <= '0;
            beat_cnt    <= '0;
            row_buf     <= '0;
            err_len     <= 1'b0;
            busy        <= 1'b1;
            if (!bank_full[wr_bank]) begin
              state       <= ST_FILL;
              bus.s_ready <= 1'b1;
            end else begin
              state <= ST_WAIT_BANK;
            end
          end
        end
        ST_WAIT_BANK: begin
          if (!bank_full[wr_bank]) begin
            state       <= ST_FILL;
            bus.s_ready <= 1'b1;
          end
        end
        ST_FILL: begin
          if (beat_ok) begin
            if (row_end) begin
              bus.we          <= 1'b1;
              bus.waddr       <= row_cnt[ADDR_WIDTH-1:0];
              bus.wdata       <= row_next;
              bus.bank_sel_wr <= wr_bank;
              row_buf         <= '0;
              beat_cnt        <= '0;
              row_cnt         <= row_cnt + 1'b1;
            end else begin
              row_buf  <= row_next;
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (tile_end) begin
              state       <= ST_DONE;
              bus.s_ready <= 1'b0;
              tile_done   <= 1'b1;
              tile_rows   <= row_cnt + 1'b1;
              err_len     <= bus.s_last ? !last_row : 1'b1;
            end
          end
        end
        ST_DONE: begin
          wr_bank <= ~wr_bank;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_act_tile_loader.sv
// Directed scoreboard bench for act_tile_loader at TM=16, ADDR_WIDTH=7, IN_W=32 (4 beats per row).
module tb_act_tile_loader;
  localparam int TM    = 16;
  localparam int AW    = 7;
  localparam int IN_W  = 32;
  localparam int ROW_W = TM * 8;
  localparam int BEATS = ROW_W / IN_W;

  typedef logic [ROW_W-1:0] v_t;
  typedef logic [AW:0]      rows_t;
  typedef struct packed { logic bank; logic [AW-1:0] addr; logic [ROW_W-1:0] data; } wr_t;
  typedef struct packed { logic [AW:0] rows; logic err; } done_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bank_release = 1'b0;
  logic        release_bank = 1'b0;
  logic [AW:0] cfg_rows = '0;
  logic        busy;
  logic        tile_done;
  logic        err_len;
  logic [1:0]  bank_full;
  logic [AW:0] tile_rows;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  logic  exp_bank = 1'b0;

  act_tile_loader_if #(.TM(TM), .ADDR_WIDTH(AW), .IN_W(IN_W)) bus();

  act_tile_loader #(.TM(TM), .ADDR_WIDTH(AW), .IN_W(IN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_rows     (cfg_rows),
    .busy         (busy),
    .bus          (bus),
    .bank_release (bank_release),
    .release_bank (release_bank),
    .bank_full    (bank_full),
    .tile_done    (tile_done),
    .tile_rows    (tile_rows),
    .err_len      (err_len)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input v_t obs, input v_t exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Writes and tile completions are popped from the scoreboard mid-cycle
  always @(negedge clk) begin : monitor
    wr_t   e;
    done_t d;
    if (rst_n && bus.we) begin
      checkOutput("we_has_expected_row", v_t'(bus.we), v_t'(wr_q.size() > 0));
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        checkOutput("wr_bank", v_t'(bus.bank_sel_wr), v_t'(e.bank));
        checkOutput("wr_addr", v_t'(bus.waddr), v_t'(e.addr));
        checkOutput("wr_data", bus.wdata, e.data);
      end
    end
    if (rst_n && tile_done) begin
      checkOutput("done_has_expected", v_t'(tile_done), v_t'(done_q.size() > 0));
      if (done_q.size() > 0) begin
        d = done_q.pop_front();
        checkOutput("tile_rows", v_t'(tile_rows), v_t'(d.rows));
        checkOutput("err_len_at_done", v_t'(err_len), v_t'(d.err));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input int rows);
    cfg_rows = rows_t'(rows);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseRelease(input logic b);
    bank_release = 1'b1;
    release_bank = b;
    tick();
    bank_release = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    checkOutput(tag, v_t'(busy), v_t'(0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, v_t'(busy), v_t'(0));
    checkOutput({tag, "_s_ready"}, v_t'(bus.s_ready), v_t'(0));
    checkOutput({tag, "_we"}, v_t'(bus.we), v_t'(0));
    checkOutput({tag, "_waddr"}, v_t'(bus.waddr), v_t'(0));
    checkOutput({tag, "_wdata"}, bus.wdata, v_t'(0));
    checkOutput({tag, "_bank_sel"}, v_t'(bus.bank_sel_wr), v_t'(0));
    checkOutput({tag, "_bank_full"}, v_t'(bank_full), v_t'(0));
    checkOutput({tag, "_tile_done"}, v_t'(tile_done), v_t'(0));
    checkOutput({tag, "_tile_rows"}, v_t'(tile_rows), v_t'(0));
    checkOutput({tag, "_err_len"}, v_t'(err_len), v_t'(0));
  endtask

  // Streams nbeats beats (s_last on beat last_at, -1 for none) and pushes the rows/tile the loader must produce
  task automatic applyStimulus(input int rows_cfg, input int nbeats, input int last_at,
                               input bit rnd, input int poke_at);
    int         target;
    int         row = 0;
    int         lane = 0;
    int         waited;
    bit         ended = 1'b0;
    bit         got;
    bit         last;
    logic [IN_W-1:0] d;
    v_t         rowv = '0;
    wr_t        w;
    done_t      dn;
    target = (rows_cfg == 0 || rows_cfg > (1 << AW)) ? (1 << AW) : rows_cfg;
    for (int i = 0; i < nbeats && !ended; i++) begin
      d    = rnd ? IN_W'($urandom) : IN_W'(i);
      last = (i == last_at);
      if (rnd) begin
        bus.s_valid = 1'b0;
        tick($urandom_range(0, 2));
      end
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      start       = (i == poke_at);
      got    = 1'b0;
      waited = 0;
      while (!got && waited < 100) begin
        got = bus.s_ready;
        tick();
        start = 1'b0;
        waited++;
      end
      checkOutput($sformatf("beat%0d_accepted", i), v_t'(got), v_t'(1));
      if (!got) break;
      rowv[lane * IN_W +: IN_W] = d;
      if (lane == BEATS - 1 || last) begin
        w.bank = exp_bank;
        w.addr = AW'(row);
        w.data = rowv;
        wr_q.push_back(w);
        rowv = '0;
        lane = 0;
        if (row == target - 1 || last) begin
          ended   = 1'b1;
          dn.rows = rows_t'(row + 1);
          dn.err  = last ? (row != target - 1) : 1'b1;
          done_q.push_back(dn);
        end
        row++;
      end else begin
        lane++;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    start       = 1'b0;
    if (ended) exp_bank = ~exp_bank;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    $display("[TB] act_tile_loader bench starting");
    tick(2);
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    // Tile 1: two rows of beat-index data into bank 0
    pulseStart(2);
    applyStimulus(2, 8, 7, 1'b0, -1);
    waitIdle("idle_t1");
    checkOutput("t1_bank_full", v_t'(bank_full), v_t'(2'b01));
    checkOutput("t1_err_len", v_t'(err_len), v_t'(0));
    checkOutput("t1_tile_rows_hold", v_t'(tile_rows), v_t'(2));

    // Tile 2 goes to bank 1
    pulseStart(2);
    applyStimulus(2, 8, 7, 1'b0, -1);
    waitIdle("idle_t2");
    checkOutput("t2_bank_full", v_t'(bank_full), v_t'(2'b11));

    // Tile 3 stalls in WAIT_BANK until bank 0 is released
    pulseStart(2);
    tick(3);
    checkOutput("t3_wait_busy", v_t'(busy), v_t'(1));
    checkOutput("t3_wait_s_ready", v_t'(bus.s_ready), v_t'(0));
    checkOutput("t3_wait_bank_full", v_t'(bank_full), v_t'(2'b11));
    pulseRelease(1'b0);
    checkOutput("t3_released", v_t'(bank_full), v_t'(2'b10));
    applyStimulus(2, 8, 7, 1'b0, -1);
    waitIdle("idle_t3");
    checkOutput("t3_bank_full", v_t'(bank_full), v_t'(2'b11));
    pulseRelease(1'b1);
    pulseRelease(1'b0);
    checkOutput("free_both", v_t'(bank_full), v_t'(2'b00));

    // Tile 4: early s_last on beat 5 with cfg_rows=4 pads row 1 and flags err_len
    pulseStart(4);
    applyStimulus(4, 6, 5, 1'b0, -1);
    waitIdle("idle_t4");
    checkOutput("t4_err_len", v_t'(err_len), v_t'(1));
    checkOutput("t4_bank_full", v_t'(bank_full), v_t'(2'b10));
    tick(3);
    checkOutput("t4_err_sticky", v_t'(err_len), v_t'(1));

    // Tile 5: cfg_rows=0 clamps to a full 128-row bank, random data and gaps
    pulseStart(0);
    checkOutput("t5_err_cleared", v_t'(err_len), v_t'(0));
    applyStimulus(0, 512, 511, 1'b1, -1);
    waitIdle("idle_t5");
    checkOutput("t5_tile_rows", v_t'(tile_rows), v_t'(128));
    checkOutput("t5_err_len", v_t'(err_len), v_t'(0));
    checkOutput("t5_bank_full", v_t'(bank_full), v_t'(2'b11));

    // Tile 6: gaps, ignored start while busy, release coincident with DONE on the same bank
    pulseRelease(1'b1);
    pulseStart(3);
    applyStimulus(3, 12, 11, 1'b1, 6);
    pulseRelease(1'b1);
    waitIdle("idle_t6");
    checkOutput("t6_set_wins", v_t'(bank_full), v_t'(2'b11));
    pulseRelease(1'b0);
    checkOutput("t6_release0", v_t'(bank_full), v_t'(2'b10));
    pulseRelease(1'b0);
    checkOutput("t6_release_nonfull", v_t'(bank_full), v_t'(2'b10));
    tick(2);
    checkOutput("t6_no_restart", v_t'(busy), v_t'(0));
    pulseRelease(1'b1);

    // Tile 7: reset asserted mid-FILL aborts everything
    pulseStart(4);
    applyStimulus(4, 6, -1, 1'b0, -1);
    checkOutput("t7_mid_fill_busy", v_t'(busy), v_t'(1));
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    checkOutput("t7_rows_drained", v_t'(wr_q.size()), v_t'(0));
    tick(2);
    exp_bank = 1'b0;
    rst_n = 1'b1;
    tick();

    // Tile 8: after reset the loader writes bank 0 from address 0 again
    pulseStart(1);
    applyStimulus(1, 4, 3, 1'b0, -1);
    waitIdle("idle_t8");
    checkOutput("t8_bank_full", v_t'(bank_full), v_t'(2'b01));
    tick(2);
    checkOutput("sb_writes_drained", v_t'(wr_q.size()), v_t'(0));
    checkOutput("sb_tiles_drained", v_t'(done_q.size()), v_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
